mfcc_tx_scheduler: RTL and testbench
====================================

# mfcc_tx_scheduler

Packetizes the two audio-front-end data sources, complete MFCC frames and raw PCM samples, into one framed byte stream for the SPI TX FIFO. It arbitrates round-robin between the sources at packet boundaries, stalls on FIFO full, and drops and counts overruns. It also sequences the MFCC core by pulsing its start once the frame buffer is free. It sits between MFCC_Core/I2S and the byte-wide tx `fifo`.

## Interface
- NUM_COEFFS, 12: coefficients per MFCC frame
- COEFF_WIDTH, 16: bits per coefficient; must be 16
- PCM_WIDTH, 16: bits per PCM sample; must be 16
- SYNC_BYTE, 8'hA5: first byte of every packet
- clk  in  1  clock
- rst_n  in  1  reset; reset rst_n, asynchronous, active-low; clock clk
- mfcc_done_i  in  1  single-cycle pulse: frame valid on mfcc_frame_i
- mfcc_frame_i  in  NUM_COEFFS*COEFF_WIDTH  coefficient k at bits [16k+15:16k]
- mfcc_start_o  out  1  single-cycle pulse re-arming MFCC core
- pcm_ready_i  in  1  single-cycle pulse: sample valid on pcm_i
- pcm_i  in  PCM_WIDTH  PCM sample
- fifo_full_i  in  1  TX FIFO full
- fifo_wr_en_o  out  1  write strobe (combinational)
- fifo_data_o  out  8  byte to write
- busy_o  out  1  packet in progress
- mfcc_drop_o  out  8  saturating count of dropped frames
- pcm_drop_o  out  8  saturating count of dropped samples

## Operation
- MFCC packet: SYNC_BYTE, 0x4D, then coeff 0..NUM_COEFFS-1 each low byte then high byte, then optional checksum. 27 bytes with checksum, 26 without.
- PCM packet: SYNC_BYTE, 0x50, sample low, sample high, optional checksum. 5 or 4 bytes.
- Checksum = XOR of the tag byte and all payload bytes. SYNC_BYTE is excluded.
- Frame buffer: one entry. mfcc_done_i when the buffer is empty captures the frame and sets mfcc_pend. When the buffer is pending or sending, the new frame is dropped and mfcc_drop_o increments, saturating at 255.
- PCM holding register: one entry. pcm_ready_i when the register is empty captures the sample. When full, the new sample is dropped and pcm_drop_o increments.
- At grant, the PCM sample is copied to the send register and pcm_pend clears the same cycle. A pcm_ready_i arriving in the grant cycle is accepted, not dropped.
- The MFCC buffer is held until its last byte is written.
- FSM states: IDLE, HDR, TAG, PAYLOAD, CSUM.
  - IDLE: if any source is pending, grant and go to HDR.
  - HDR → TAG → PAYLOAD. Each transition occurs only on an accepted write.
  - PAYLOAD: byte index 0..2N-1; after the last byte go to CSUM, or to IDLE when the macro is off.
  - CSUM → IDLE.
- Arbitration: if both sources are pending, grant the one not granted last. last_grant resets to PCM, so MFCC wins the first tie. Packets are atomic; there is no preemption.
- mfcc_start_o pulses in the cycle after the last byte of an MFCC packet is accepted. It also pulses once in the first cycle after reset release.
- busy_o = state != IDLE.

## Timing
- A write is accepted in any cycle with fifo_wr_en_o=1.
- fifo_wr_en_o = (state != IDLE) && !fifo_full_i. fifo_data_o is valid in the same cycle.
- At most one byte is written per cycle. There are no bubbles inside a packet while FIFO is not full.
- Latency: a pending source in IDLE writes SYNC_BYTE in the next cycle.
- Back-to-back packets have one IDLE cycle between them.
- fifo_full_i high: the FSM holds state and the byte index, and data is stable.
- A capture pulse in the same cycle that the buffer frees (last byte accepted) is dropped. The buffer frees one cycle later.
- Reset values: fifo_wr_en_o=0, fifo_data_o=0, busy_o=0, mfcc_start_o=0, both drop counters=0. Pending flags clear and last_grant=PCM.
- Reset mid-packet aborts immediately with no further writes. The host resynchronises on SYNC_BYTE.

## Configuration
- TX_SCHED_CHECKSUM_EN defined: every packet ends with the XOR checksum byte, and the CSUM state is present.
- TX_SCHED_CHECKSUM_EN undefined: CSUM is removed, and PAYLOAD goes directly to IDLE.

## Test plan
- PCM 0x1234, FIFO never full, macro on → 5 consecutive writes A5 50 34 12 76. Macro off → A5 50 34 12.
- MFCC frame with coeff k = 0x0100+k, macro on → 27 bytes: A5 4D, then pairs (k,01) for k=0..11, then 4D. mfcc_start_o pulses one cycle after the last write.
- MFCC and PCM pending in the same cycle after reset → MFCC packet first, then one IDLE cycle, then the PCM packet. On the next tie, PCM goes first.
- fifo_full_i held high for 10 cycles mid-payload → no writes and byte unchanged; the stream resumes intact and the total byte count is unchanged.
- Three pcm_ready_i pulses (samples 0x0001, 0x0002, 0x0003) during an MFCC packet → 0x0001 is sent, and pcm_drop_o=2. 300 drops → pcm_drop_o=255.
- rst_n asserted after byte 10 of an MFCC packet → fifo_wr_en_o=0 immediately and all outputs reset. After release, mfcc_start_o pulses once.

Source files
------------

// File: rtl/mfcc_tx_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : mfcc_tx_scheduler                                           |
// | Description: Packetizes MFCC frames and PCM samples into a framed byte   |
// |              stream for the SPI TX FIFO. Round-robin arbitration at      |
// |              packet boundaries, FIFO-full stalling, overrun drop counts, |
// |              and MFCC core re-arm sequencing.                            |
// | Config     : TX_SCHED_CHECKSUM_EN appends an XOR checksum byte to every  |
// |              packet (tag and payload bytes, sync byte excluded).         |
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module mfcc_tx_scheduler #(
  parameter int          NUM_COEFFS  = 12,
  parameter int          COEFF_WIDTH = 16,
  parameter int          PCM_WIDTH   = 16,
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              mfcc_done_i,
  input  logic [NUM_COEFFS*COEFF_WIDTH-1:0] mfcc_frame_i,
  output logic                              mfcc_start_o,
  input  logic                              pcm_ready_i,
  input  logic [PCM_WIDTH-1:0]              pcm_i,
  input  logic                              fifo_full_i,
  output logic                              fifo_wr_en_o,
  output logic [7:0]                        fifo_data_o,
  output logic                              busy_o,
  output logic [7:0]                        mfcc_drop_o,
  output logic [7:0]                        pcm_drop_o
);

  localparam int FRAME_W = NUM_COEFFS * COEFF_WIDTH;
  localparam int NBYTES  = 2 * NUM_COEFFS;
  localparam int IDX_W   = (NBYTES > 2) ? $clog2(NBYTES) : 1;
  localparam int OFF_W   = $clog2(FRAME_W);
  localparam logic [7:0]       TAG_MFCC  = 8'h4D;
  localparam logic [7:0]       TAG_PCM   = 8'h50;
  localparam logic [IDX_W-1:0] LAST_MFCC = IDX_W'(NBYTES - 1);
  localparam logic [IDX_W-1:0] LAST_PCM  = IDX_W'(1);

`ifdef TX_SCHED_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, HDR, TAG, PAYLOAD, CSUM} state_t;
`else
  typedef enum logic [1:0] {IDLE, HDR, TAG, PAYLOAD} state_t;
`endif

  state_t               state, next_state;
  logic [FRAME_W-1:0]   mfcc_buf;
  logic                 mfcc_pend, mfcc_sending;
  logic [PCM_WIDTH-1:0] pcm_hold, pcm_send;
  logic                 pcm_pend;
  logic                 cur_mfcc, last_grant_mfcc;
  logic [IDX_W-1:0]     idx, last_idx;
  logic                 first_start;
  logic                 grant_mfcc, grant_pcm, pkt_done;
  logic [OFF_W-1:0]     bit_off;
  logic [7:0]           mfcc_byte, pcm_byte, payload_byte;
`ifdef TX_SCHED_CHECKSUM_EN
  logic [7:0]           csum;
`endif

  assign bit_off      = OFF_W'({idx, 3'b000});
  assign mfcc_byte    = mfcc_buf[bit_off +: 8];
  assign pcm_byte     = idx[0] ? pcm_send[15:8] : pcm_send[7:0];
  assign payload_byte = cur_mfcc ? mfcc_byte : pcm_byte;
  assign last_idx     = cur_mfcc ? LAST_MFCC : LAST_PCM;
  assign busy_o       = (state != IDLE);

  // State register; reset aborts any packet in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state, grant decision and byte-stream outputs.
  always_comb begin
    next_state   = state;
    grant_mfcc   = 1'b0;
    grant_pcm    = 1'b0;
    pkt_done     = 1'b0;
    fifo_wr_en_o = (state != IDLE) && !fifo_full_i;
    fifo_data_o  = 8'h00;
    case (state)
      IDLE: begin
        // On a tie, the source not granted last wins.
        if (mfcc_pend && (!pcm_pend || !last_grant_mfcc)) begin
          grant_mfcc = 1'b1;
          next_state = HDR;
        end else if (pcm_pend) begin
          grant_pcm  = 1'b1;
          next_state = HDR;
        end
      end
      HDR: begin
        fifo_data_o = SYNC_BYTE;
        if (fifo_wr_en_o) next_state = TAG;
      end
      TAG: begin
        fifo_data_o = cur_mfcc ? TAG_MFCC : TAG_PCM;
        if (fifo_wr_en_o) next_state = PAYLOAD;
      end
      PAYLOAD: begin
        fifo_data_o = payload_byte;
        if (fifo_wr_en_o && (idx == last_idx)) begin
`ifdef TX_SCHED_CHECKSUM_EN
          next_state = CSUM;
`else
          next_state = IDLE;
          pkt_done   = 1'b1;
`endif
        end
      end
`ifdef TX_SCHED_CHECKSUM_EN
      CSUM: begin
        fifo_data_o = csum;
        if (fifo_wr_en_o) begin
          next_state = IDLE;
          pkt_done   = 1'b1;
        end
      end
`endif
      default: next_state = IDLE;
    endcase
  end

  // Grant bookkeeping and payload byte index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_mfcc        <= 1'b0;
      last_grant_mfcc <= 1'b0;
      idx             <= '0;
    end else if (grant_mfcc || grant_pcm) begin
      cur_mfcc        <= grant_mfcc;
      last_grant_mfcc <= grant_mfcc;
      idx             <= '0;
    end else if (fifo_wr_en_o && (state == PAYLOAD)) begin
      idx <= idx + IDX_W'(1);
    end
  end

  // MFCC frame buffer: held until its last byte is accepted, freed one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mfcc_buf     <= '0;
      mfcc_pend    <= 1'b0;
      mfcc_sending <= 1'b0;
      mfcc_drop_o  <= 8'h00;
    end else begin
      if (grant_mfcc) begin
        mfcc_pend    <= 1'b0;
        mfcc_sending <= 1'b1;
      end else if (pkt_done && cur_mfcc) begin
        mfcc_sending <= 1'b0;
      end
      if (mfcc_done_i) begin
        if (mfcc_pend || mfcc_sending) begin
          if (mfcc_drop_o != 8'hFF) mfcc_drop_o <= mfcc_drop_o + 8'd1;
        end else begin
          mfcc_buf  <= mfcc_frame_i;
          mfcc_pend <= 1'b1;
        end
      end
    end
  end

  // PCM holding register; emptied into the send register at grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcm_hold   <= '0;
      pcm_send   <= '0;
      pcm_pend   <= 1'b0;
      pcm_drop_o <= 8'h00;
    end else begin
      if (grant_pcm) begin
        pcm_send <= pcm_hold;
        pcm_pend <= 1'b0;
      end
      // A sample arriving in the grant cycle lands in the freed register.
      if (pcm_ready_i) begin
        if (pcm_pend && !grant_pcm) begin
          if (pcm_drop_o != 8'hFF) pcm_drop_o <= pcm_drop_o + 8'd1;
        end else begin
          pcm_hold <= pcm_i;
          pcm_pend <= 1'b1;
        end
      end
    end
  end

  // MFCC core re-arm: once after reset release and after each MFCC packet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_start  <= 1'b1;
      mfcc_start_o <= 1'b0;
    end else begin
      first_start  <= 1'b0;
      mfcc_start_o <= first_start || (pkt_done && cur_mfcc);
    end
  end

`ifdef TX_SCHED_CHECKSUM_EN
  // Running XOR over tag and payload bytes as they are accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csum <= 8'h00;
    end else if (fifo_wr_en_o) begin
      if (state == HDR)          csum <= 8'h00;
      else if (state == TAG)     csum <= fifo_data_o;
      else if (state == PAYLOAD) csum <= csum ^ fifo_data_o;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_mfcc_tx_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : tb_mfcc_tx_scheduler                                        |
// | Description: Directed self-checking bench for mfcc_tx_scheduler; follows |
// |              TX_SCHED_CHECKSUM_EN to select expected packet lengths.     |
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module tb_mfcc_tx_scheduler;
  localparam int N = 12;
`ifdef TX_SCHED_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif
  localparam int L = 26 + CS;   // MFCC packet length
  localparam int P = 4 + CS;    // PCM packet length

  logic            clk = 1'b0;
  logic            rst_n;
  logic            mfcc_done_i;
  logic [N*16-1:0] mfcc_frame_i;
  logic            mfcc_start_o;
  logic            pcm_ready_i;
  logic [15:0]     pcm_i;
  logic            fifo_full_i;
  logic            fifo_wr_en_o;
  logic [7:0]      fifo_data_o;
  logic            busy_o;
  logic [7:0]      mfcc_drop_o;
  logic [7:0]      pcm_drop_o;

  mfcc_tx_scheduler dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mfcc_done_i (mfcc_done_i),
    .mfcc_frame_i(mfcc_frame_i),
    .mfcc_start_o(mfcc_start_o),
    .pcm_ready_i (pcm_ready_i),
    .pcm_i       (pcm_i),
    .fifo_full_i (fifo_full_i),
    .fifo_wr_en_o(fifo_wr_en_o),
    .fifo_data_o (fifo_data_o),
    .busy_o      (busy_o),
    .mfcc_drop_o (mfcc_drop_o),
    .pcm_drop_o  (pcm_drop_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  int         wcyc_q[$];
  int         start_q[$];

  // Byte and start-pulse collector, sampled mid-cycle.
  always @(negedge clk) begin
    if (fifo_wr_en_o) begin
      got_q.push_back(fifo_data_o);
      wcyc_q.push_back(cyc);
    end
    if (mfcc_start_o) start_q.push_back(cyc);
  end

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int wc(input int i);
    return (i >= 0 && wcyc_q.size() > i) ? wcyc_q[i] : -1;
  endfunction

  function automatic logic [N*16-1:0] frame(input logic [15:0] base);
    logic [N*16-1:0] f;
    for (int k = 0; k < N; k++) f[16*k +: 16] = base + 16'(k);
    return f;
  endfunction

  task automatic add_pcm(input logic [15:0] s);
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h50);
    exp_q.push_back(s[7:0]);
    exp_q.push_back(s[15:8]);
    if (CS != 0) exp_q.push_back(8'h50 ^ s[7:0] ^ s[15:8]);
  endtask

  task automatic add_mfcc(input logic [15:0] base);
    logic [7:0]  x;
    logic [15:0] c;
    x = 8'h4D;
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h4D);
    for (int k = 0; k < N; k++) begin
      c = base + 16'(k);
      exp_q.push_back(c[7:0]);
      exp_q.push_back(c[15:8]);
      x = x ^ c[7:0] ^ c[15:8];
    end
    if (CS != 0) exp_q.push_back(x);
  endtask

  task automatic cmp_stream(input string tag);
    int n;
    chk({tag, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      chk($sformatf("%s_b%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
  endtask

  task automatic clear_all();
    got_q.delete();
    exp_q.delete();
    wcyc_q.delete();
    start_q.delete();
  endtask

  initial begin
    int t0;
    rst_n        = 1'b0;
    mfcc_done_i  = 1'b0;
    mfcc_frame_i = '0;
    pcm_ready_i  = 1'b0;
    pcm_i        = 16'h0000;
    fifo_full_i  = 1'b0;

    // Reset values
    tick(3);
    chk("rst_wr_en", 32'(fifo_wr_en_o), 32'd0);
    chk("rst_data", 32'(fifo_data_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_start", 32'(mfcc_start_o), 32'd0);
    chk("rst_mdrop", 32'(mfcc_drop_o), 32'd0);
    chk("rst_pdrop", 32'(pcm_drop_o), 32'd0);
    rst_n = 1'b1;
    tick(1);
    chk("start_after_rst", 32'(mfcc_start_o), 32'd1);
    tick(1);
    chk("start_after_rst_end", 32'(mfcc_start_o), 32'd0);
    clear_all();

    // Tie after reset: MFCC first, one IDLE cycle, then PCM
    t0 = cyc;
    mfcc_done_i = 1'b1; mfcc_frame_i = frame(16'h0100);
    pcm_ready_i = 1'b1; pcm_i = 16'h1234;
    tick(1);
    mfcc_done_i = 1'b0; pcm_ready_i = 1'b0;
    chk("tie_idle_busy", 32'(busy_o), 32'd0);
    tick(1);
    chk("tie_hdr_busy", 32'(busy_o), 32'd1);
    chk("tie_hdr_wr", 32'(fifo_wr_en_o), 32'd1);
    chk("tie_hdr_data", 32'(fifo_data_o), 32'hA5);
    tick(38);
    add_mfcc(16'h0100);
    add_pcm(16'h1234);
    cmp_stream("tie1");
    chk("tie1_latency", wc(0), t0 + 2);
    chk("tie1_mfcc_contig", wc(L - 1), t0 + 1 + L);
    chk("tie1_pcm_sync_cyc", wc(L), t0 + 3 + L);
    chk("tie1_pcm_contig", wc(L + P - 1), t0 + 2 + L + P);
    chk("tie1_start_cnt", 32'(start_q.size()), 32'd1);
    chk("tie1_start_cyc", (start_q.size() > 0) ? start_q[0] : -1, t0 + 2 + L);
    clear_all();

    // MFCC with a 10-cycle FIFO stall mid-payload; 3 PCM pulses during it
    t0 = cyc;
    mfcc_done_i = 1'b1; mfcc_frame_i = frame(16'h3C80);
    tick(1);
    mfcc_done_i = 1'b0;
    tick(6);
    fifo_full_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      pcm_ready_i = (i == 2 || i == 4 || i == 6);
      pcm_i       = 16'((i / 2));
      #1;
      chk($sformatf("stall_wr_%0d", i), 32'(fifo_wr_en_o), 32'd0);
      chk($sformatf("stall_data_%0d", i), 32'(fifo_data_o), 32'h3C);
      tick(1);
    end
    pcm_ready_i = 1'b0;
    fifo_full_i = 1'b0;
    tick(40);
    add_mfcc(16'h3C80);
    add_pcm(16'h0001);
    cmp_stream("stall");
    chk("stall_span", wc(L - 1), t0 + 11 + L);
    chk("stall_pdrop", 32'(pcm_drop_o), 32'd2);
    chk("stall_mdrop", 32'(mfcc_drop_o), 32'd0);
    clear_all();

    // MFCC drops while sending and in the last-byte cycle; capture one cycle later
    t0 = cyc;
    mfcc_done_i = 1'b1; mfcc_frame_i = frame(16'h5A00);
    tick(1);
    mfcc_done_i = 1'b0;
    tick(4);
    mfcc_done_i = 1'b1; mfcc_frame_i = frame(16'h7700);
    tick(1);
    mfcc_done_i = 1'b0;
    tick(L - 5);
    chk("last_byte_wr", 32'(fifo_wr_en_o), 32'd1);
    mfcc_done_i = 1'b1; mfcc_frame_i = frame(16'h7700);
    tick(1);
    chk("freed_start", 32'(mfcc_start_o), 32'd1);
    mfcc_frame_i = frame(16'h6600);
    tick(1);
    mfcc_done_i = 1'b0;
    tick(L + 6);
    add_mfcc(16'h5A00);
    add_mfcc(16'h6600);
    cmp_stream("mdrop");
    chk("mdrop_cnt", 32'(mfcc_drop_o), 32'd2);
    clear_all();

    // Tie after an MFCC grant: PCM goes first
    mfcc_done_i = 1'b1; mfcc_frame_i = frame(16'h0100);
    pcm_ready_i = 1'b1; pcm_i = 16'hBEEF;
    tick(1);
    mfcc_done_i = 1'b0; pcm_ready_i = 1'b0;
    tick(45);
    add_pcm(16'hBEEF);
    add_mfcc(16'h0100);
    cmp_stream("tie2");
    chk("tie2_gap", wc(P) - wc(P - 1), 2);
    clear_all();

    // 300 PCM pulses with the FIFO full: counter saturates
    fifo_full_i = 1'b1;
    for (int i = 0; i < 300; i++) begin
      pcm_ready_i = 1'b1;
      pcm_i       = 16'(i);
      tick(1);
    end
    pcm_ready_i = 1'b0;
    chk("sat_pdrop", 32'(pcm_drop_o), 32'd255);
    chk("sat_no_wr", 32'(got_q.size()), 32'd0);
    fifo_full_i = 1'b0;
    tick(20);
    add_pcm(16'h0000);
    add_pcm(16'h0001);
    cmp_stream("sat");
    clear_all();

    // Reset after byte 10 of an MFCC packet
    mfcc_done_i = 1'b1; mfcc_frame_i = frame(16'h0100);
    tick(1);
    mfcc_done_i = 1'b0;
    tick(11);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_wr_en", 32'(fifo_wr_en_o), 32'd0);
    chk("arst_data", 32'(fifo_data_o), 32'd0);
    chk("arst_busy", 32'(busy_o), 32'd0);
    chk("arst_mdrop", 32'(mfcc_drop_o), 32'd0);
    chk("arst_pdrop", 32'(pcm_drop_o), 32'd0);
    tick(2);
    start_q.delete();
    rst_n = 1'b1;
    tick(10);
    add_mfcc(16'h0100);
    exp_q = exp_q[0:9];
    cmp_stream("arst");
    chk("arst_start_cnt", 32'(start_q.size()), 32'd1);
    chk("arst_idle", 32'(busy_o), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
